// File: rtl/ddr3_pixel_packer_writer_if.sv
// Pixel stream and DDR3 write-request bundle between the canny write-back path
// and the pixel packer.
interface ddr3_pixel_packer_writer_if;
  logic         frame_start;
  logic         pix_valid;
  logic         pix_ready;
  logic [7:0]   pix_data;
  logic         wr_en;
  logic [31:0]  sdram_address;
  logic [127:0] write_data_input;
  logic         write_complete;
  logic         frame_done;
  logic [15:0]  words_written;

  modport master (
    output frame_start, pix_valid, pix_data, write_complete,
    input  pix_ready, wr_en, sdram_address, write_data_input, frame_done, words_written
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, write_complete,
    output pix_ready, wr_en, sdram_address, write_data_input, frame_done, words_written
  );
endinterface

// File: rtl/ddr3_pixel_packer_writer.sv
// Packs 16 grayscale pixels per 128-bit word and issues one single-beat DDR3
// write per word, walking a frame linearly from BASE_ADDR.

module ddr3_ppw_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] din,
  output logic [7:0] byte_o
);
  logic [7:0] byte_q, byte_d;

  // byte_o includes this cycle's write so lane 15 can hand off in the accept cycle
  always_comb begin
    byte_d = we ? din : byte_q;
  end
  assign byte_o = byte_d;

  always_ff @(posedge clk) begin
    if (!rst_n) byte_q <= '0;
    else        byte_q <= byte_d;
  end
endmodule

module ddr3_pixel_packer_writer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned FRAME_PIXELS = 307200
) (
  input  logic                             main_clk,
  input  logic                             main_reset_n,
  ddr3_pixel_packer_writer_if.slave        bus
);
  localparam int          NUM_LANES   = 16;
  localparam int          VEC_W       = 8;
  localparam logic [15:0] FRAME_WORDS = 16'(FRAME_PIXELS / NUM_LANES);
  localparam logic [15:0] LAST_WORD   = 16'(FRAME_WORDS - 16'd1);

  typedef enum logic {W_IDLE, W_BUSY} wstate_e;

  wstate_e                         state_q, state_d;
  logic [4:0]                      pcnt_q, pcnt_d;
  logic [31:0]                     word_addr_q, word_addr_d;
  logic [31:0]                     addr_q, addr_d;
  logic [127:0]                    data_q, data_d;
  logic [15:0]                     issued_q, issued_d;
  logic [15:0]                     written_q, written_d;
  logic                            stale_q, stale_d;
  logic                            done_q, done_d;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_nx;
  logic [NUM_LANES-1:0]            lane_we;
  logic                            accept, free, xfer, complete;

  assign bus.pix_ready = (pcnt_q < 5'(NUM_LANES)) && !bus.frame_start;
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign complete      = (state_q == W_BUSY) && bus.write_complete;
  assign free          = (state_q == W_IDLE) || bus.write_complete;
  assign xfer          = !bus.frame_start && free &&
                         ((pcnt_q == 5'(NUM_LANES)) || (accept && pcnt_q == 5'(NUM_LANES - 1)));

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign lane_we[k] = accept && (pcnt_q == 5'(k));
      ddr3_ppw_lane u_lane (
        .clk    (main_clk),
        .rst_n  (main_reset_n),
        .we     (lane_we[k]),
        .din    (bus.pix_data),
        .byte_o (lane_nx[k])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    word_addr_d = word_addr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    issued_d    = issued_q;
    written_d   = written_q;
    stale_d     = stale_q;
    done_d      = 1'b0;

    if (accept)   pcnt_d  = pcnt_q + 5'd1;
    if (complete) state_d = W_IDLE;

    if (xfer) begin
      state_d = W_BUSY;
      data_d  = lane_nx;
      addr_d  = word_addr_q;
      pcnt_d  = '0;
      if (issued_q == LAST_WORD) begin
        issued_d    = '0;
        word_addr_d = BASE_ADDR;
      end else begin
        issued_d    = issued_q + 16'd1;
        word_addr_d = word_addr_q + 32'd16;
      end
    end

    // a word issued before the last frame_start finishes but is not credited to the new frame
    if (complete && !stale_q) begin
      if (written_q == LAST_WORD) begin
        written_d = '0;
        done_d    = 1'b1;
      end else begin
        written_d = written_q + 16'd1;
      end
    end
    if (xfer || complete) stale_d = 1'b0;

    if (bus.frame_start) begin
      pcnt_d      = '0;
      word_addr_d = BASE_ADDR;
      issued_d    = '0;
      written_d   = '0;
      done_d      = 1'b0;
      stale_d     = (state_q == W_BUSY) && !bus.write_complete;
    end
  end

  always_ff @(posedge main_clk) begin
    if (!main_reset_n) begin
      state_q     <= W_IDLE;
      pcnt_q      <= '0;
      word_addr_q <= BASE_ADDR;
      addr_q      <= BASE_ADDR;
      data_q      <= '0;
      issued_q    <= '0;
      written_q   <= '0;
      stale_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      word_addr_q <= word_addr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      issued_q    <= issued_d;
      written_q   <= written_d;
      stale_q     <= stale_d;
      done_q      <= done_d;
    end
  end

  assign bus.wr_en            = (state_q == W_BUSY);
  assign bus.sdram_address    = addr_q;
  assign bus.write_data_input = data_q;
  assign bus.frame_done       = done_q;
  assign bus.words_written    = written_q;
endmodule

// File: tb/tb_ddr3_pixel_packer_writer.sv
// Directed bench for the pixel packer: 2-word frames at 0x1000, an automatic
// write_complete responder with programmable delay, and per-scenario checks.
module tb_ddr3_pixel_packer_writer;
  logic main_clk = 1'b0;
  logic main_reset_n;
  ddr3_pixel_packer_writer_if bus ();

  ddr3_pixel_packer_writer #(.BASE_ADDR(32'h1000), .FRAME_PIXELS(32)) dut (
    .main_clk     (main_clk),
    .main_reset_n (main_reset_n),
    .bus          (bus)
  );

  always #5 main_clk = ~main_clk;

  int total = 0;
  int bad   = 0;
  int ncomp = 0;
  bit resp_en = 1'b0;
  bit manual_wc = 1'b0;
  int resp_delay = 2;
  int resp_cnt = 0;
  logic [31:0]  cq_addr[$];
  logic [127:0] cq_data[$];

  // responder decides write_complete at negedge and logs accepted words
  initial begin
    bus.write_complete = 1'b0;
    forever begin
      @(negedge main_clk);
      bus.write_complete = manual_wc;
      if (resp_en && bus.wr_en) begin
        if (resp_cnt == resp_delay) begin
          bus.write_complete = 1'b1;
          resp_cnt = 0;
        end else resp_cnt++;
      end else resp_cnt = 0;
      if (bus.wr_en && bus.write_complete) begin
        cq_addr.push_back(bus.sdram_address);
        cq_data.push_back(bus.write_data_input);
        ncomp++;
      end
    end
  end

  task automatic tick();
    @(posedge main_clk); #1;
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    #1;
    while (!bus.pix_ready && n < 200) begin tick(); n++; end
    if (n >= 200) begin total++; bad++; $display("FAIL push_timeout pix=%h ready=%0b want=1", d, bus.pix_ready); end
    tick();
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_comp(input int target);
    int n = 0;
    while (ncomp < target && n < 200) begin tick(); n++; end
    if (ncomp < target) begin total++; bad++; $display("FAIL comp_timeout got=%0d want=%0d", ncomp, target); end
  endtask

  task automatic pulse_frame_start();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    main_reset_n = 1'b0;
    repeat (3) tick();
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%0b want=0", bus.wr_en); end
    total++; if (bus.sdram_address !== 32'h1000) begin bad++; $display("FAIL rst_addr got=%h want=00001000", bus.sdram_address); end
    total++; if (bus.words_written !== 16'd0) begin bad++; $display("FAIL rst_ww got=%0d want=0", bus.words_written); end
    total++; if (bus.write_data_input !== 128'd0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.write_data_input); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", bus.frame_done); end
    main_reset_n = 1'b1;
    tick();
    total++; if (bus.pix_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", bus.pix_ready); end
  endtask

  task automatic test_single_word();
    resp_delay = 2; resp_en = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL sw_wr_en got=%0b want=1", bus.wr_en); end
    total++; if (bus.sdram_address !== 32'h1000) begin bad++; $display("FAIL sw_addr got=%h want=00001000", bus.sdram_address); end
    total++; if (bus.write_data_input !== 128'h0F0E0D0C0B0A09080706050403020100) begin bad++; $display("FAIL sw_data got=%h", bus.write_data_input); end
    tick(); tick();
    total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL sw_hold got=%0b want=1", bus.wr_en); end
    tick();
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL sw_drop got=%0b want=0", bus.wr_en); end
    total++; if (bus.words_written !== 16'd1) begin bad++; $display("FAIL sw_ww got=%0d want=1", bus.words_written); end
  endtask

  task automatic test_backpressure();
    int base;
    pulse_frame_start();
    base = ncomp;
    resp_delay = 20;
    for (int i = 0; i < 32; i++) push(8'(i));
    total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b want=0", bus.pix_ready); end
    total++; if (bus.sdram_address !== 32'h1000) begin bad++; $display("FAIL bp_addr0 got=%h want=00001000", bus.sdram_address); end
    wait_comp(base + 1);
    total++; if (cq_addr[base] !== 32'h1000) begin bad++; $display("FAIL bp_comp0_addr got=%h want=00001000", cq_addr[base]); end
    total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL bp_no_idle got=%0b want=1", bus.wr_en); end
    total++; if (bus.sdram_address !== 32'h1010) begin bad++; $display("FAIL bp_addr1 got=%h want=00001010", bus.sdram_address); end
    total++; if (bus.write_data_input !== 128'h1F1E1D1C1B1A19181716151413121110) begin bad++; $display("FAIL bp_data1 got=%h", bus.write_data_input); end
    total++; if (bus.pix_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0b want=1", bus.pix_ready); end
    total++; if (bus.words_written !== 16'd1) begin bad++; $display("FAIL bp_ww got=%0d want=1", bus.words_written); end
  endtask

  task automatic test_frame_wrap();
    int base = ncomp;
    wait_comp(base + 1);
    total++; if (cq_addr[base] !== 32'h1010) begin bad++; $display("FAIL fw_comp1_addr got=%h want=00001010", cq_addr[base]); end
    total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL fw_done got=%0b want=1", bus.frame_done); end
    total++; if (bus.words_written !== 16'd0) begin bad++; $display("FAIL fw_ww got=%0d want=0", bus.words_written); end
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL fw_wr_en got=%0b want=0", bus.wr_en); end
    tick();
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL fw_done_pulse got=%0b want=0", bus.frame_done); end
    resp_delay = 2;
    for (int i = 0; i < 16; i++) push(8'(8'h50 + i));
    total++; if (bus.sdram_address !== 32'h1000) begin bad++; $display("FAIL fw_wrap_addr got=%h want=00001000", bus.sdram_address); end
    wait_comp(base + 2);
    tick();
    total++; if (bus.words_written !== 16'd1) begin bad++; $display("FAIL fw_ww2 got=%0d want=1", bus.words_written); end
  endtask

  task automatic test_frame_start();
    int base = ncomp;
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
    bus.pix_valid = 1'b1; bus.pix_data = 8'hEE; bus.frame_start = 1'b1;
    #1;
    total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL fs_ready got=%0b want=0", bus.pix_ready); end
    tick();
    bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
    total++; if (bus.words_written !== 16'd0) begin bad++; $display("FAIL fs_ww_clr got=%0d want=0", bus.words_written); end
    for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
    total++; if (bus.sdram_address !== 32'h1000) begin bad++; $display("FAIL fs_addr got=%h want=00001000", bus.sdram_address); end
    total++; if (bus.write_data_input !== 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0) begin bad++; $display("FAIL fs_data got=%h", bus.write_data_input); end
    wait_comp(base + 1);
    tick();
    total++; if (bus.words_written !== 16'd1) begin bad++; $display("FAIL fs_ww got=%0d want=1", bus.words_written); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL fs_done got=%0b want=0", bus.frame_done); end
  endtask

  task automatic test_reset_midflight();
    int base;
    resp_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 7; i++)  push(8'(8'h40 + i));
    total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL rm_pre_wr_en got=%0b want=1", bus.wr_en); end
    main_reset_n = 1'b0;
    tick();
    main_reset_n = 1'b1;
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rm_wr_en got=%0b want=0", bus.wr_en); end
    total++; if (bus.sdram_address !== 32'h1000) begin bad++; $display("FAIL rm_addr got=%h want=00001000", bus.sdram_address); end
    total++; if (bus.write_data_input !== 128'd0) begin bad++; $display("FAIL rm_data got=%h want=0", bus.write_data_input); end
    total++; if (bus.words_written !== 16'd0) begin bad++; $display("FAIL rm_ww got=%0d want=0", bus.words_written); end
    manual_wc = 1'b1;
    tick();
    manual_wc = 1'b0;
    tick();
    total++; if (bus.words_written !== 16'd0) begin bad++; $display("FAIL rm_stray_wc got=%0d want=0", bus.words_written); end
    base = ncomp;
    resp_en = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    total++; if (bus.write_data_input !== 128'h6F6E6D6C6B6A69686766656463626160) begin bad++; $display("FAIL rm_pcnt_clr got=%h", bus.write_data_input); end
    total++; if (bus.sdram_address !== 32'h1000) begin bad++; $display("FAIL rm_addr2 got=%h want=00001000", bus.sdram_address); end
    wait_comp(base + 1);
    tick();
    total++; if (bus.words_written !== 16'd1) begin bad++; $display("FAIL rm_ww2 got=%0d want=1", bus.words_written); end
  endtask

  initial begin
    main_reset_n    = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = 8'h00;
    test_reset();
    test_single_word();
    test_backpressure();
    test_frame_wrap();
    test_frame_start();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
